// File: rtl/pc_update.sv
// rtl/pc_update.sv - Y86-64 program counter register, next-PC select and status FSM (optional PC_RETIRE_CNT_EN retire counter)
module pc_update #(
    parameter int          DATA_WID  = 64,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned IMEM_SIZE = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          icode,
    input  logic [DATA_WID-1:0] valP,
    input  logic [DATA_WID-1:0] valC,
    input  logic [DATA_WID-1:0] valM,
    input  logic                cnd,
    input  logic                instr_valid,
    input  logic                imem_error,
    input  logic                stall,
`ifdef PC_RETIRE_CNT_EN
    output logic [DATA_WID-1:0] retired,
`endif
    output logic [DATA_WID-1:0] pc,
    output logic [1:0]          stat,
    output logic                running
);

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [DATA_WID-1:0] PC_INIT    = DATA_WID'(RESET_PC);
    localparam logic [DATA_WID-1:0] IMEM_LIMIT = DATA_WID'(IMEM_SIZE);

    typedef enum logic [1:0] {
        S_RUN,
        S_HALT,
        S_FAULT
    } state_t;

    state_t              state, state_next;
    logic [DATA_WID-1:0] pc_next;
    logic [DATA_WID-1:0] new_pc;
    logic [1:0]          stat_next;

    // Next-fetch address select, independent of whether it gets committed
    always_comb begin
        new_pc = valP;
        case (icode)
            I_CALL:  new_pc = valC;
            I_JXX:   new_pc = cnd ? valC : valP;
            I_RET:   new_pc = valM;
            default: new_pc = valP;
        endcase
    end

    // Priority-ordered commit/fault decision; HALT and FAULT simply hold everything
    always_comb begin
        state_next = state;
        pc_next    = pc;
        stat_next  = stat;
        if (state == S_RUN && !stall) begin
            if (imem_error) begin
                state_next = S_FAULT;
                stat_next  = STAT_ADR;
            end else if (!instr_valid) begin
                state_next = S_FAULT;
                stat_next  = STAT_INS;
            end else if (icode == I_HALT) begin
                state_next = S_HALT;
                stat_next  = STAT_HLT;
            end else if (new_pc >= IMEM_LIMIT) begin
                state_next = S_FAULT;
                stat_next  = STAT_ADR;
            end else begin
                pc_next = new_pc;
            end
        end
    end

    // State, PC and status registers; running is decoded from the next state so it drops with stat
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RUN;
            pc      <= PC_INIT;
            stat    <= STAT_AOK;
            running <= 1'b1;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            stat    <= stat_next;
            running <= (state_next == S_RUN);
        end
    end

`ifdef PC_RETIRE_CNT_EN
    logic commit;

    // A halt counts as retired; any fault does not
    assign commit = (state == S_RUN) && !stall && !imem_error && instr_valid &&
                    ((icode == I_HALT) || (new_pc < IMEM_LIMIT));

    // Saturating count of committed instructions
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (commit && (retired != {DATA_WID{1'b1}})) begin
            retired <= retired + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_update.sv
// tb/tb_pc_update.sv - scoreboard bench for pc_update
module tb_pc_update;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  icode;
    logic [63:0] valP, valC, valM;
    logic        cnd, instr_valid, imem_error, stall;
    logic [63:0] pc;
    logic [1:0]  stat;
    logic        running;
    logic [63:0] retired;

    typedef struct {
        logic [63:0] pc;
        logic [1:0]  stat;
        logic        run;
        logic [63:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [63:0] ret_model = 0;

    always #5 clk = ~clk;

    pc_update #(.DATA_WID(64), .RESET_PC(0), .IMEM_SIZE(4096)) dut (
        .clk         (clk),
        .rst         (rst),
        .icode       (icode),
        .valP        (valP),
        .valC        (valC),
        .valM        (valM),
        .cnd         (cnd),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .stall       (stall),
`ifdef PC_RETIRE_CNT_EN
        .retired     (retired),
`endif
        .pc          (pc),
        .stat        (stat),
        .running     (running)
    );

`ifndef PC_RETIRE_CNT_EN
    assign retired = 64'd0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, ".pc"}, pc, e.pc);
        check({tag, ".stat"}, {62'd0, stat}, {62'd0, e.stat});
        check({tag, ".running"}, {63'd0, running}, {63'd0, e.run});
`ifdef PC_RETIRE_CNT_EN
        check({tag, ".retired"}, retired, e.ret);
`endif
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        rst = 1'b1;
        ret_model = 0;
        e = '{pc: 64'd0, stat: 2'd0, run: 1'b1, ret: 64'd0};
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pop_compare(tag);
    endtask

    task automatic drive(input string tag, input logic [3:0] ic,
                         input logic [63:0] p, input logic [63:0] c, input logic [63:0] m,
                         input logic cd, input logic iv, input logic ie, input logic st,
                         input logic [63:0] epc, input logic [1:0] est, input logic erun,
                         input logic bump);
        exp_t e;
        icode = ic; valP = p; valC = c; valM = m;
        cnd = cd; instr_valid = iv; imem_error = ie; stall = st;
        if (bump) ret_model = ret_model + 1;
        e = '{pc: epc, stat: est, run: erun, ret: ret_model};
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_compare(tag);
    endtask

    initial begin
        rst = 1'b0; icode = 4'h1; valP = 0; valC = 0; valM = 0;
        cnd = 0; instr_valid = 1; imem_error = 0; stall = 0;
        #2;
        do_reset("reset");

        // tag  icode  valP  valC  valM  cnd iv ie st  exp_pc stat run bump
        drive("nop",      4'h1, 64'h1,   64'h0,   64'h0,  0, 1, 0, 0, 64'h1,   2'd0, 1, 1);
        drive("nop2",     4'h1, 64'h10,  64'h0,   64'h0,  0, 1, 0, 0, 64'h10,  2'd0, 1, 1);
        drive("jxx_tk",   4'h7, 64'h19,  64'h40,  64'h0,  1, 1, 0, 0, 64'h40,  2'd0, 1, 1);
        drive("jxx_nt",   4'h7, 64'h19,  64'h40,  64'h0,  0, 1, 0, 0, 64'h19,  2'd0, 1, 1);
        drive("call",     4'h8, 64'h22,  64'h100, 64'h0,  0, 1, 0, 0, 64'h100, 2'd0, 1, 1);
        drive("ret",      4'h9, 64'h101, 64'h77,  64'h19, 0, 1, 0, 0, 64'h19,  2'd0, 1, 1);
        drive("opq",      4'h6, 64'h30,  64'h200, 64'h0,  1, 1, 0, 0, 64'h30,  2'd0, 1, 1);
        drive("edge_ok",  4'h1, 64'hFFF, 64'h0,   64'h0,  0, 1, 0, 0, 64'hFFF, 2'd0, 1, 1);

        for (int i = 0; i < 3; i++)
            drive("stall_err", 4'h1, 64'h20, 64'h0, 64'h0, 0, 1, 1, 1, 64'hFFF, 2'd0, 1, 0);
        drive("stall_rel", 4'h1, 64'h20, 64'h0, 64'h0, 0, 1, 1, 0, 64'hFFF, 2'd2, 0, 0);
        drive("fault_abs", 4'h1, 64'h20, 64'h0, 64'h0, 0, 1, 0, 0, 64'hFFF, 2'd2, 0, 0);

        do_reset("reset2");
        drive("to30",  4'h1, 64'h30, 64'h0, 64'h0, 0, 1, 0, 0, 64'h30, 2'd0, 1, 1);
        drive("halt",  4'h0, 64'h32, 64'h0, 64'h0, 0, 1, 0, 0, 64'h30, 2'd1, 0, 1);
        for (int i = 0; i < 10; i++)
            drive("halt_hold", 4'($urandom_range(0, 15)), 64'($urandom), 64'($urandom), 64'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 64'h30, 2'd1, 0, 0);
        do_reset("reset3");

        drive("nop_at_lim", 4'h1, 64'd4096, 64'h0, 64'h0, 0, 1, 0, 0, 64'h0, 2'd2, 0, 0);
        do_reset("reset4");
        drive("ins",        4'h1, 64'h2, 64'h0, 64'h0, 0, 0, 0, 0, 64'h0, 2'd3, 0, 0);
        do_reset("reset5");
        drive("adr_prio",   4'h1, 64'h2, 64'h0, 64'h0, 0, 0, 1, 0, 64'h0, 2'd2, 0, 0);
        do_reset("reset6");
        drive("ret_wrap",   4'h9, 64'h2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 64'h0, 2'd2, 0, 0);
        do_reset("reset7");
        drive("call_far",   4'h8, 64'h9, 64'h1000, 64'h0, 0, 1, 0, 0, 64'h0, 2'd2, 0, 0);
        do_reset("reset8");
        drive("jxx_nt_far", 4'h7, 64'h9, 64'h5000, 64'h0, 0, 1, 0, 0, 64'h9, 2'd0, 1, 1);
        drive("halt_stall", 4'h0, 64'hB, 64'h0, 64'h0, 0, 1, 0, 1, 64'h9, 2'd0, 1, 0);
        do_reset("reset_mid_stall");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pc_update.md
# pc_update

Program-counter register and next-PC selector for the Y86-64 sequential core. It sits directly downstream of the PC increment stage: it consumes `valP` together with `valC`, `valM`, `icode` and `cnd` from the current instruction. On each clock edge it commits the next fetch address, or freezes it. It also owns the processor status state machine (AOK/HLT/ADR/INS) that stops fetch on halt or fault.

## Interface
- `DATA_WID`, 64: address/data width.
- `RESET_PC`, 0: PC value loaded on reset.
- `IMEM_SIZE`, 4096: instruction memory size in bytes. Any committed PC ≥ `IMEM_SIZE` is an address fault.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `icode`  input  4  icode of the instruction at `pc`.
- `valP`  input  DATA_WID  fall-through address from the increment stage.
- `valC`  input  DATA_WID  instruction constant (jump/call target).
- `valM`  input  DATA_WID  memory read value (return address for RET).
- `cnd`  input  1  condition result for JXX.
- `instr_valid`  input  1  decoded icode/ifun is legal.
- `imem_error`  input  1  fetch of current instruction faulted.
- `stall`  input  1  hold the current instruction; no commit this cycle.
- `pc`  output  DATA_WID  current fetch address.
- `stat`  output  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- `running`  output  1  high only in state RUN.

## Operation
- States: RUN, HALT, FAULT. `stat` is the registered status.
- Reset: `pc`=`RESET_PC`, state=RUN, `stat`=AOK, `running`=1.
- In RUN with `stall`=1: `pc`, state and `stat` hold. Fault inputs are ignored while stalled.
- In RUN with `stall`=0, the first matching rule in this order applies:
  1. `imem_error`=1: state→FAULT, `stat`=ADR, `pc` holds.
  2. `instr_valid`=0: state→FAULT, `stat`=INS, `pc` holds.
  3. `icode`=HALT (0): state→HALT, `stat`=HLT, `pc` holds at the halt instruction.
  4. Otherwise compute `newPC`:
     - CALL (8): `valC`.
     - JXX (7) with `cnd`=1: `valC`.
     - RET (9): `valM`.
     - all other icodes: `valP`.
  5. If `newPC` ≥ `IMEM_SIZE`: state→FAULT, `stat`=ADR, `pc` holds.
  6. Else `pc`←`newPC`.
- HALT and FAULT are absorbing. All inputs are ignored, and only `rst` returns the block to RUN.
- Arithmetic: the comparison is unsigned, full DATA_WID. There is no wrap handling; an address that wraps past 2^64 is already ≥ `IMEM_SIZE`.
- `rst` asserted in any state, including mid-stall, wins over all other inputs.

## Timing
- The block is a single register stage. `newPC` and the fault checks are combinational from the inputs. `pc`, `stat` and `running` change only at the clock edge.
- Latency: an instruction presented in cycle N yields the updated `pc` in cycle N+1.
- `running` is a registered decode of the state. It falls in the same cycle that `stat` leaves AOK.
- `stall` is sampled each edge and has no handshake beyond that. Upstream holds all inputs stable while `stall`=1.

## Configuration
- `PC_RETIRE_CNT_EN`. When defined, an extra output `retired` (DATA_WID) is added:
  - It counts committed instructions: it increments on every RUN, non-stalled edge that takes rule 4/6, and on the edge that enters HALT.
  - Reset value is 0. It holds in HALT/FAULT and saturates at all-ones.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Reset then NOP, `valP`=0x1 → next cycle `pc`=0x1, `stat`=0, `running`=1.
- `pc`=0x10, JXX with `cnd`=1, `valC`=0x40 → `pc`=0x40. Same with `cnd`=0, `valP`=0x19 → `pc`=0x19.
- CALL with `valC`=0x100, then RET with `valM`=0x19 → `pc` goes 0x100 then 0x19.
- `stall`=1 for 3 cycles while `imem_error`=1 → `pc` and `stat` unchanged. Releasing the stall → `stat`=2, `pc` unchanged, `running`=0.
- HALT at `pc`=0x30 → `stat`=1 and `pc` stays 0x30 for 10 cycles despite toggling inputs. `rst` → `pc`=`RESET_PC`, `stat`=0. With `PC_RETIRE_CNT_EN`, `retired` counts the halt and then resets to 0.
- `valP`=`IMEM_SIZE` on a NOP → `stat`=2. `instr_valid`=0 → `stat`=3. `imem_error` and `instr_valid`=0 together → `stat`=2.
